// File: rtl/u01_pkg.sv
// u01_pkg: shared constants, FSM state type and arithmetic helpers for the
// multi-channel uniform generator.
//   xs32_step  : one xorshift32 step (13/17/5 shifts)
//   u24_to_f32 : exact conversion of a 24-bit fraction k/2^24 to float32
package u01_pkg;

  localparam int XS_A        = 13;
  localparam int XS_B        = 17;
  localparam int XS_C        = 5;
  localparam int FP_BIAS_OFF = 103;  // 127 - 24: exponent bias minus fraction width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } u01_state_e;

  function automatic logic [31:0] xs32_step(input logic [31:0] x);
    logic [31:0] v;
    v = x ^ (x << XS_A);
    v = v ^ (v >> XS_B);
    v = v ^ (v << XS_C);
    return v;
  endfunction

  // Priority encoder finds the MSB position p; the value k/2^24 is then
  // 2^(p-24) * 1.frac, so no rounding is ever needed.
  function automatic logic [31:0] u24_to_f32(input logic [23:0] k);
    logic [4:0]  p;
    logic [7:0]  e;
    logic [23:0] sh;
    p = '0;
    for (int i = 0; i < 24; i++) begin
      if (k[i]) p = 5'(i);
    end
    e  = 8'(FP_BIAS_OFF) + {3'b000, p};
    sh = k << (5'd23 - p);
    if (k == '0) return 32'h0000_0000;
    return {1'b0, e, sh[22:0]};
  endfunction

endpackage

// File: rtl/u01_lane.sv
// u01_lane: one channel of the uniform generator.
//   clk, rst      : clock, async active-high reset
//   i_load        : load i_seed_state into the xorshift state (has priority)
//   i_seed_state  : full 32-bit initial state for this channel
//   i_step        : advance the xorshift state by one step
//   i_capture     : register conv(next state) into o_data
//   o_data        : float32 uniform for this channel
module u01_lane
  import u01_pkg::*;
#(
  parameter int OPEN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [31:0] i_seed_state,
  input  logic        i_step,
  input  logic        i_capture,
  output logic [31:0] o_data
);

  logic [31:0] r_state;
  logic [31:0] r_data;
  logic [31:0] w_next;
  logic [23:0] w_k;

  assign w_next = xs32_step(r_state);
  // OPEN forces the LSB high so k is never 0 and the result lies in (0,1)
  assign w_k    = {w_next[31:9], (OPEN != 0)};
  assign o_data = r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= '0;
      r_data  <= '0;
    end else begin
      if (i_load) begin
        r_state <= i_seed_state;
      end else if (i_step) begin
        r_state <= w_next;
      end
      if (i_capture && !i_load) begin
        r_data <= u24_to_f32(w_k);
      end
    end
  end

endmodule

// File: rtl/u01_vec.sv
// u01_vec: NUM_CH parallel xorshift32 uniform generators with shared seeding,
// optional warm-up discard and a valid/ready output.
//   clk, rst  : clock, async active-high reset
//   en, seed  : seed-load strobe and 23-bit seed
//   out_valid : out_data holds a fresh vector
//   out_ready : consumer accepts the vector
//   out_data  : float32 per channel, channel c at [32c+31:32c]
//   busy      : high while discarding warm-up steps
module u01_vec
  import u01_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WARMUP = 16,
  parameter int OPEN   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [22:0]           seed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*NUM_CH-1:0]  out_data,
  output logic                  busy
);

  localparam logic [15:0] WARM_INIT = 16'(WARMUP);

  u01_state_e  r_state;
  logic [15:0] r_cnt;
  logic        r_valid;
  logic        r_busy;

  logic w_fire;
  logic w_step;
  logic w_capture;

  assign w_fire    = out_ready | ~r_valid;
  // en wins over any stepping in the same cycle
  assign w_capture = ~en & (r_state == ST_RUN) & w_fire;
  assign w_step    = ~en & ((r_state == ST_WARM) | ((r_state == ST_RUN) & w_fire));

  assign out_valid = r_valid;
  assign busy      = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else if (en) begin
      r_valid <= 1'b0;
      if (WARMUP == 0) begin
        r_state <= ST_RUN;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
      end else begin
        r_state <= ST_WARM;
        r_cnt   <= WARM_INIT;
        r_busy  <= 1'b1;
      end
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_valid <= 1'b0;
        end
        ST_WARM: begin
          r_cnt <= r_cnt - 16'd1;
          if (r_cnt == 16'd1) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_fire) r_valid <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    logic [31:0] w_seed_state;
    // low nine ones guarantee a nonzero xorshift state for any seed
    assign w_seed_state = {seed ^ 23'(c), 9'h1FF};

    u01_lane #(.OPEN(OPEN)) u_lane (
      .clk          (clk),
      .rst          (rst),
      .i_load       (en),
      .i_seed_state (w_seed_state),
      .i_step       (w_step),
      .i_capture    (w_capture),
      .o_data       (out_data[32*c +: 32])
    );
  end

endmodule

// File: doc/u01_vec.md
# u01_vec

Parametrised multi-channel uniform (0,1) generator for the Heston Monte-Carlo path engine. It produces NUM_CH independent IEEE-754 single-precision uniforms per transfer, using one xorshift32 core per channel. Seeding is shared, and an optional warm-up discard runs after each seed load. Output uses a valid/ready handshake so downstream Box-Muller / variance-update stages can stall it.

## Interface
- NUM_CH, 4: number of channels, 1..512.
- WARMUP, 16: xorshift steps discarded after each seed load, 0..65535.
- OPEN, 1: 1 gives open interval (0,1); 0 gives half-open [0,1).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  seed-load strobe, sampled on the rising edge.
- seed  in  23  seed value, sampled when en=1.
- out_valid  out  1  out_data holds a fresh vector.
- out_ready  in  1  consumer accepts the vector.
- out_data  out  32*NUM_CH  float32 per channel; channel c sits at bits [32c+31:32c].
- busy  out  1  high in the WARM state.

## Operation
- FSM has three states: IDLE, WARM, RUN.
- Reset values: state=IDLE, out_valid=0, out_data=0, busy=0, all channel states=0, warm counter=0.
- Seed load, when en=1 in any state:
  - channel c state <= {seed ^ c (zero-extended to 23 bits), 9'h1FF}; the state is never zero.
  - out_valid <= 0.
  - Go to WARM with counter=WARMUP, or to RUN if WARMUP=0.
  - en overrides every other activity that cycle.
- IDLE: no stepping; out_valid stays 0; en is the only exit.
- WARM:
  - Each cycle every channel steps; counter decrements.
  - On the step where counter==1, go to RUN.
  - out_ready is ignored.
- RUN:
  - Fire condition: out_ready | ~out_valid.
  - When it fires, every channel steps to x' and out_data[c] <= conv(x'); out_valid <= 1.
  - Otherwise all state and out_data hold.
- Step (xorshift32): x ^= x<<13; x ^= x>>17; x ^= x<<5.
- Conversion conv(x):
  - m = x[31:9].
  - k = {m,1'b1} if OPEN, else {m,1'b0}; k is 24 bits.
  - k==0 (possible only when OPEN=0): output 32'h00000000.
  - Otherwise, with p = index of the MSB of k:
    - sign=0
    - exponent = 103+p
    - mantissa = (k << (23-p))[22:0]
  - The result is exactly k/2^24 with no rounding; it never reaches 1.0.

## Timing
- Load edge is E0. Warm steps occur on E1..E_WARMUP. The first vector is registered on E_(WARMUP+1).
- out_valid is therefore first high WARMUP+1 cycles after en.
- Throughput: one vector per cycle while out_ready=1.
- Stall: out_data and the channel states are frozen while out_valid=1 and out_ready=0. No sample is lost or repeated.
- en while out_valid=1 and out_ready=1: the pending vector counts as consumed; out_valid drops the next cycle.
- Reset asserted mid-WARM or mid-RUN: immediate return to reset values. No output appears until the next en.
- Conversion is combinational in front of the out_data register. No extra pipeline stage.

## Structure
- Shared package u01_pkg holds:
  - localparam XS_A=13, XS_B=17, XS_C=5
  - localparam FP_BIAS_OFF=103
  - function xs32_step
  - function u24_to_f32, which contains the priority encoder
- Sub-module u01_lane: one channel's state register, step logic and conversion. It takes a shared load/step control from the top-level FSM.
- Top level: FSM, warm counter, handshake, and the generate loop over NUM_CH lanes.

## Test plan
- NUM_CH=4, OPEN=1, WARMUP=0, seed=0, out_ready=1, en pulse -> channel 0 state 0x000001FF. The first out_valid cycle after the load edge shows channel 0 = 32'h3CF87BA0, since the step gives 0x07C3DDE0.
- Same stimulus with OPEN=0 -> channel 0 = 32'h3CF87B80.
- WARMUP=16, seed=232 -> busy high for 16 cycles; out_valid rises exactly 17 cycles after en. The vector equals the 17th xorshift output of the reference model, for all 4 channels.
- Run 100 vectors, holding out_ready low for cycles 10-14 -> out_data is stable during the stall. The accepted sequence matches the model with no gap or duplicate.
- Reseed with seed=5 in mid-run while stalled -> out_valid drops the cycle after en. The new first vector matches the seed-5 model.
- rst pulse during WARM -> all outputs go to 0 asynchronously; no valid appears until the next en. Across 10000 samples per channel in both modes, no output equals 0x3F800000; with OPEN=1, no output equals 0.
